// File: rtl/magnetron_ctrl_pwm.sv
// Clocked magnetron controller: synchronised front-panel buttons and door, a
// four-state cook FSM and a frame-based power-level PWM with a combinational door interlock.
module magnetron_ctrl_pwm #(
  parameter int PWR_BITS     = 3,
  parameter int FRAME_CYCLES = 16,
  parameter int CNT_W        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                startn,
  input  logic                stopn,
  input  logic                clearn,
  input  logic                door_closed,
  input  logic                timer_done,
  input  logic [PWR_BITS-1:0] power_level,
  output logic                mag_on,
  output logic [1:0]          state,
  output logic                done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_COOK   = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  localparam logic [CNT_W:0]   STEP     = (CNT_W+1)'(FRAME_CYCLES / (2 ** PWR_BITS));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);

  // Buttons packed as {start, stop, clear}; the third stage is the edge reference
  logic [2:0]          btn_meta_r, btn_sync_r, btn_prev_r;
  logic                door_meta_r, door_sync_r, door_prev_r;
  logic [2:0]          press_s;
  logic                start_press_s, stop_press_s, clear_press_s, door_fall_s;

  state_t              state_r, state_next_s;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic [PWR_BITS-1:0] duty_r, duty_next_s;
  logic [CNT_W:0]      on_cycles_s;
  logic                mag_q_r, mag_next_s;
  logic                done_r;

  // Two-flop synchronisers plus previous-value flops for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_r  <= 3'b111;
      btn_sync_r  <= 3'b111;
      btn_prev_r  <= 3'b111;
      door_meta_r <= 1'b0;
      door_sync_r <= 1'b0;
      door_prev_r <= 1'b0;
    end else begin
      btn_meta_r  <= {startn, stopn, clearn};
      btn_sync_r  <= btn_meta_r;
      btn_prev_r  <= btn_sync_r;
      door_meta_r <= door_closed;
      door_sync_r <= door_meta_r;
      door_prev_r <= door_sync_r;
    end
  end

  assign press_s       = btn_prev_r & ~btn_sync_r;
  assign start_press_s = press_s[2];
  assign stop_press_s  = press_s[1];
  assign clear_press_s = press_s[0];
  assign door_fall_s   = door_prev_r & ~door_sync_r;

  // Next-state logic, priority clear > timer_done > door open > stop > start
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_press_s) begin
          state_next_s = ST_IDLE;
        end else if (start_press_s && door_sync_r && !timer_done) begin
          state_next_s = ST_COOK;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_COOK: begin
        if (clear_press_s) begin
          state_next_s = ST_IDLE;
        end else if (timer_done) begin
          state_next_s = ST_DONE;
        end else if (!door_sync_r || stop_press_s) begin
          state_next_s = ST_PAUSED;
        end else begin
          state_next_s = ST_COOK;
        end
      end
      ST_PAUSED: begin
        if (clear_press_s) begin
          state_next_s = ST_IDLE;
        end else if (timer_done) begin
          state_next_s = ST_DONE;
        end else if (start_press_s && door_sync_r) begin
          state_next_s = ST_COOK;
        end else begin
          state_next_s = ST_PAUSED;
        end
      end
      ST_DONE: begin
        if (clear_press_s || door_fall_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Frame counter, frame-boundary duty capture and next PWM output level
  always_comb begin
    cnt_next_s  = {CNT_W{1'b0}};
    duty_next_s = duty_r;
    if (state_next_s == ST_COOK) begin
      if (state_r != ST_COOK) begin
        cnt_next_s = {CNT_W{1'b0}};
      end else if (cnt_r == LAST_CNT) begin
        cnt_next_s = {CNT_W{1'b0}};
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end
      // Counter at 0 covers both COOK entry and every new frame
      if (cnt_next_s == {CNT_W{1'b0}}) begin
        duty_next_s = power_level;
      end else begin
        duty_next_s = duty_r;
      end
    end else begin
      cnt_next_s  = {CNT_W{1'b0}};
      duty_next_s = duty_r;
    end
    on_cycles_s = ((CNT_W+1)'(duty_next_s) + (CNT_W+1)'(1)) * STEP;
    mag_next_s  = (state_next_s == ST_COOK) && ({1'b0, cnt_next_s} < on_cycles_s);
  end

  // State, PWM and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      duty_r  <= {PWR_BITS{1'b0}};
      mag_q_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      duty_r  <= duty_next_s;
      mag_q_r <= mag_next_s;
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Interlock uses the raw door pin so opening the door needs no clock
  assign mag_on = mag_q_r & door_closed;
  assign state  = state_r;
  assign done   = done_r;

endmodule
